// File: rtl/param_mem_processor.sv
// param_mem_processor: parametrised FETCH/EXE/MEM core with an rw/ack memory handshake.
// Build with MEM_TIMEOUT_EN defined to trap to ERR when a memory ack takes TIMEOUT_CYC cycles.
module param_mem_processor #(
   parameter int WORD_WIDTH  = 16,
   parameter int ADDR_WIDTH  = 16,
   parameter int REG_NUM     = 4,
   parameter int PC_WIDTH    = 8,
   parameter int TIMEOUT_CYC = 64,
   localparam int RIDX_W     = $clog2(REG_NUM),
   localparam int INSTR_W    = 3 + RIDX_W + WORD_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [INSTR_W-1:0]    instruction,
   output logic [PC_WIDTH-1:0]   pcCounter,
   output logic [WORD_WIDTH-1:0] data,
   output logic                  halted,
   output logic                  errFlag,
   output logic [1:0]            rwToMem,
   output logic [ADDR_WIDTH-1:0] addrToMem,
   output logic [WORD_WIDTH-1:0] dataToMem,
   input  logic                  rdEn,
   input  logic                  wtEn,
   input  logic [WORD_WIDTH-1:0] dataFromMem
);

   typedef enum logic [2:0] {
      ST_FETCH = 3'd0,
      ST_EXE   = 3'd1,
      ST_MEM   = 3'd2,
      ST_HALT  = 3'd3,
      ST_ERR   = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      OP_NOP  = 3'd0,
      OP_SET  = 3'd1,
      OP_GET  = 3'd2,
      OP_LD   = 3'd3,
      OP_ST   = 3'd4,
      OP_ADD  = 3'd5,
      OP_BNZ  = 3'd6,
      OP_HALT = 3'd7
   } op_t;

   typedef enum logic [1:0] {
      RW_IDLE = 2'd0,
      RW_RD   = 2'd1,
      RW_WT   = 2'd2
   } rw_t;

   if (ADDR_WIDTH > WORD_WIDTH || PC_WIDTH > WORD_WIDTH || REG_NUM < 2 ||
       (1 << RIDX_W) != REG_NUM || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_param
      $error("param_mem_processor: illegal parameter combination");
   end

   state_t                  state_r;
   rw_t                     rw_r;
   logic [PC_WIDTH-1:0]     pc_r;
   logic [INSTR_W-1:0]      ir_r;
   logic [WORD_WIDTH-1:0]   regs_r [REG_NUM];
   logic [WORD_WIDTH-1:0]   data_r;
   logic                    halted_r;
   logic                    err_r;
   logic [ADDR_WIDTH-1:0]   addr_r;
   logic [WORD_WIDTH-1:0]   wdata_r;

`ifdef MEM_TIMEOUT_EN
   localparam logic [15:0]  WAIT_LAST = 16'(TIMEOUT_CYC - 1);
   logic [15:0]             wait_cnt_r;
`endif

   op_t                     op_s;
   logic [RIDX_W-1:0]       ridx_s;
   logic [WORD_WIDTH-1:0]   imm_s;
   logic [WORD_WIDTH-1:0]   rval_s;
   logic [ADDR_WIDTH-1:0]   addr_s;

   // Field decode of the held instruction word.
   always_comb begin
      op_s   = op_t'(ir_r[INSTR_W-1 -: 3]);
      ridx_s = ir_r[WORD_WIDTH +: RIDX_W];
      imm_s  = ir_r[WORD_WIDTH-1:0];
      rval_s = regs_r[ridx_s];
      addr_s = imm_s[ADDR_WIDTH-1:0];
   end

   // Core state machine with all architectural state and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r  <= ST_FETCH;
         rw_r     <= RW_IDLE;
         pc_r     <= '0;
         ir_r     <= '0;
         data_r   <= '0;
         halted_r <= 1'b0;
         err_r    <= 1'b0;
         addr_r   <= '0;
         wdata_r  <= '0;
         for (int i = 0; i < REG_NUM; i++) begin
            regs_r[i] <= '0;
         end
`ifdef MEM_TIMEOUT_EN
         wait_cnt_r <= 16'd0;
`endif
      end else begin
         case (state_r)
            ST_FETCH: begin
               ir_r    <= instruction;
               pc_r    <= pc_r + PC_WIDTH'(1);
               rw_r    <= RW_IDLE;
               state_r <= ST_EXE;
            end
            ST_EXE: begin
               state_r <= ST_FETCH;
`ifdef MEM_TIMEOUT_EN
               wait_cnt_r <= 16'd0;
`endif
               case (op_s)
                  OP_NOP: begin
                     state_r <= ST_FETCH;
                  end
                  OP_SET: regs_r[ridx_s] <= imm_s;
                  OP_GET: data_r <= rval_s;
                  OP_LD: begin
                     rw_r    <= RW_RD;
                     addr_r  <= addr_s;
                     state_r <= ST_MEM;
                  end
                  OP_ST: begin
                     rw_r    <= RW_WT;
                     addr_r  <= addr_s;
                     wdata_r <= rval_s;
                     state_r <= ST_MEM;
                  end
                  OP_ADD: regs_r[ridx_s] <= rval_s + imm_s;
                  // A taken branch replaces the pc already incremented in FETCH.
                  OP_BNZ: begin
                     if (rval_s != '0) begin
                        pc_r <= imm_s[PC_WIDTH-1:0];
                     end
                  end
                  OP_HALT: begin
                     halted_r <= 1'b1;
                     state_r  <= ST_HALT;
                  end
                  default: begin
                     err_r   <= 1'b1;
                     state_r <= ST_ERR;
                  end
               endcase
            end
            ST_MEM: begin
               // Simultaneous acks are a protocol violation; wrong-kind acks are ignored.
               if (rdEn && wtEn) begin
                  err_r   <= 1'b1;
                  rw_r    <= RW_IDLE;
                  state_r <= ST_ERR;
               end else if (rdEn && op_s == OP_LD) begin
                  regs_r[ridx_s] <= dataFromMem;
                  rw_r           <= RW_IDLE;
                  state_r        <= ST_FETCH;
               end else if (wtEn && op_s == OP_ST) begin
                  rw_r    <= RW_IDLE;
                  state_r <= ST_FETCH;
`ifdef MEM_TIMEOUT_EN
               end else if (wait_cnt_r == WAIT_LAST) begin
                  err_r   <= 1'b1;
                  rw_r    <= RW_IDLE;
                  state_r <= ST_ERR;
               end else begin
                  wait_cnt_r <= wait_cnt_r + 16'd1;
               end
`else
               end else begin
                  state_r <= ST_MEM;
               end
`endif
            end
            ST_HALT: begin
               rw_r <= RW_IDLE;
            end
            ST_ERR: begin
               err_r <= 1'b1;
               rw_r  <= RW_IDLE;
            end
            default: begin
               err_r   <= 1'b1;
               rw_r    <= RW_IDLE;
               state_r <= ST_ERR;
            end
         endcase
      end
   end

   assign pcCounter = pc_r;
   assign data      = data_r;
   assign halted    = halted_r;
   assign errFlag   = err_r;
   assign rwToMem   = rw_r;
   assign addrToMem = addr_r;
   assign dataToMem = wdata_r;

endmodule
